// File: rtl/jtag_dr_regfile_pkg.sv
// Shared definitions for the JTAG user-DR register file.
//   Register map addresses, command-register bit positions and helpers
//   that locate the fields inside the data register (DR).
//   No ports: imported by jtag_dr_regfile and jtag_nonce_fifo.
package jtag_comm_pkg;

   localparam int unsigned REG_VERSION  = 0;
   localparam int unsigned REG_NONCE_LO = 1;
   localparam int unsigned REG_NONCE_HI = 2;
   localparam int unsigned REG_STATUS   = 3;
   localparam int unsigned REG_CTRL     = 4;
   localparam int unsigned REG_CMD      = 5;

   localparam int unsigned CMD_CLR_OVF  = 0;
   localparam int unsigned CMD_FLUSH    = 1;

   // DR layout, LSB first: data | addr | wr flag | pad
   function automatic int unsigned dr_width(int unsigned data_w, int unsigned addr_w);
      return data_w + addr_w + 2;
   endfunction

   function automatic int unsigned dr_addr_lsb(int unsigned data_w);
      return data_w;
   endfunction

   function automatic int unsigned dr_wr_bit(int unsigned data_w, int unsigned addr_w);
      return data_w + addr_w;
   endfunction

endpackage

// File: rtl/jtag_dr_regfile_if.sv
// JTAG user-chain signals as seen behind the BSCAN primitive.
//   jt_sel      USER instruction selected
//   jt_capture  Capture-DR
//   jt_shift    Shift-DR
//   jt_update   Update-DR
//   jt_tdi      serial data toward the register file
//   jt_tdo      serial data from the register file
// master: BSCAN side (drives controls, reads tdo); slave: register file.
interface jtag_dr_regfile_if;
   logic jt_sel;
   logic jt_capture;
   logic jt_shift;
   logic jt_update;
   logic jt_tdi;
   logic jt_tdo;

   modport master (
      output jt_sel, jt_capture, jt_shift, jt_update, jt_tdi,
      input  jt_tdo
   );

   modport slave (
      input  jt_sel, jt_capture, jt_shift, jt_update, jt_tdi,
      output jt_tdo
   );
endinterface

// File: rtl/jtag_dr_regfile_fifo.sv
// jtag_nonce_fifo: synchronous first-word-fall-through FIFO for nonces.
//   clk, rst    clock, asynchronous active-high reset
//   push, din   enqueue din; accepted when not full, or when full with a pop
//   pop         dequeue head; ignored when empty
//   flush       empty the FIFO; overrides push and pop
//   head        current head entry (stale when empty)
//   count       entries held, 0..DEPTH
//   full, empty status
module jtag_nonce_fifo
   import jtag_comm_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 61
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   input  logic                     flush,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

   // A pop in the same cycle frees the slot a push into a full FIFO needs.
   assign do_pop  = pop & ~empty & ~flush;
   assign do_push = push & ~flush & (~full | do_pop);

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Power-of-two depth: pointers wrap by natural overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

endmodule

// File: rtl/jtag_dr_regfile.sv
// jtag_dr_regfile: JTAG user-DR engine giving the host read/write access
// to a small register file, with a nonce FIFO popped by host reads.
//   jt_tck       TCK, sole clock
//   jt_reset     asynchronous active-high reset
//   jtag         user-chain signals (slave modport), tdo = dr[0]
//   nonce_push   enqueue nonce_data this cycle (already in TCK domain)
//   nonce_data   nonce incl. found flag
//   ctrl         writable control register
//   fifo_count   entries held in the nonce FIFO
//   overflow     sticky, set when a push was dropped on a full FIFO
// Writes are accepted only when an odd number of ones was shifted in.
module jtag_dr_regfile
   import jtag_comm_pkg::*;
#(
   parameter int unsigned          DATA_W     = 32,
   parameter int unsigned          ADDR_W     = 4,
   parameter int unsigned          NONCE_W    = 61,
   parameter int unsigned          FIFO_DEPTH = 8,
   parameter logic [DATA_W-1:0]    VERSION    = 32'h01000200,
   parameter logic [DATA_W-1:0]    CTRL_RESET = '0
) (
   input  logic                          jt_tck,
   input  logic                          jt_reset,
   jtag_dr_regfile_if.slave              jtag,
   input  logic                          nonce_push,
   input  logic [NONCE_W-1:0]            nonce_data,
   output logic [DATA_W-1:0]             ctrl,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow
);

   localparam int unsigned DR_W     = dr_width(DATA_W, ADDR_W);
   localparam int unsigned ADDR_LSB = dr_addr_lsb(DATA_W);
   localparam int unsigned WR_BIT   = dr_wr_bit(DATA_W, ADDR_W);

   logic [DR_W-1:0]    dr;
   logic               parity;
   logic [ADDR_W-1:0]  addr_ptr;
   logic [DATA_W-1:0]  rd_data;
   logic [DATA_W-1:0]  nonce_lo_word;
   logic [DATA_W-1:0]  nonce_hi_word;
   logic [DATA_W-1:0]  status_word;

   logic               cap_en;
   logic               sh_en;
   logic               upd_ok;
   logic [ADDR_W-1:0]  dr_addr;
   logic [DATA_W-1:0]  dr_data;
   logic               dr_wr;
   logic               wr_ctrl;
   logic               wr_cmd;
   logic               clr_ovf;

   logic [NONCE_W-1:0] fifo_head;
   logic               fifo_full;
   logic               fifo_empty;
   logic               fifo_pop;
   logic               fifo_flush;
   logic               push_drop;

   assign cap_en  = jtag.jt_sel & jtag.jt_capture;
   assign sh_en   = jtag.jt_sel & ~jtag.jt_capture & jtag.jt_shift;
   // parity starts at 1 on capture, so 0 here means an odd count of ones
   assign upd_ok  = jtag.jt_sel & ~jtag.jt_capture & ~jtag.jt_shift
                  & jtag.jt_update & ~parity;

   assign dr_data = dr[DATA_W-1:0];
   assign dr_addr = dr[ADDR_LSB +: ADDR_W];
   assign dr_wr   = dr[WR_BIT];

   assign wr_ctrl    = upd_ok & dr_wr & (dr_addr == ADDR_W'(REG_CTRL));
   assign wr_cmd     = upd_ok & dr_wr & (dr_addr == ADDR_W'(REG_CMD));
   assign clr_ovf    = wr_cmd & dr_data[CMD_CLR_OVF];
   assign fifo_flush = wr_cmd & dr_data[CMD_FLUSH];

   // Reading the high half retires the nonce; the host reads low first.
   assign fifo_pop  = cap_en & (addr_ptr == ADDR_W'(REG_NONCE_HI)) & ~fifo_empty;
   assign push_drop = nonce_push & fifo_full & ~fifo_pop & ~fifo_flush;

   assign jtag.jt_tdo = dr[0];

   jtag_nonce_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (NONCE_W)
   ) u_fifo (
      .clk   (jt_tck),
      .rst   (jt_reset),
      .push  (nonce_push),
      .din   (nonce_data),
      .pop   (fifo_pop),
      .flush (fifo_flush),
      .head  (fifo_head),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Valid/overflow flags sit in the MSB; the field in between is zero pad.
   always_comb begin
      nonce_lo_word = '0;
      nonce_hi_word = '0;
      if (!fifo_empty) begin
         nonce_lo_word = DATA_W'(fifo_head);
         nonce_hi_word = DATA_W'(fifo_head >> DATA_W);
         nonce_hi_word[DATA_W-1] = 1'b1;
      end
      status_word = DATA_W'(fifo_count);
      status_word[DATA_W-1] = overflow;
   end

   always_comb begin
      rd_data = '1;
      case (addr_ptr)
         ADDR_W'(REG_VERSION):  rd_data = VERSION;
         ADDR_W'(REG_NONCE_LO): rd_data = nonce_lo_word;
         ADDR_W'(REG_NONCE_HI): rd_data = nonce_hi_word;
         ADDR_W'(REG_STATUS):   rd_data = status_word;
         ADDR_W'(REG_CTRL):     rd_data = ctrl;
         default:               rd_data = '1;
      endcase
   end

   // addr_ptr is one-shot: every capture re-arms it to the all-ones address.
   always_ff @(posedge jt_tck or posedge jt_reset) begin
      if (jt_reset) begin
         dr       <= '0;
         parity   <= 1'b1;
         addr_ptr <= '1;
      end else if (cap_en) begin
         dr       <= DR_W'(rd_data);
         parity   <= 1'b1;
         addr_ptr <= '1;
      end else if (sh_en) begin
         dr       <= {jtag.jt_tdi, dr[DR_W-1:1]};
         parity   <= parity ^ jtag.jt_tdi;
      end else if (upd_ok) begin
         addr_ptr <= dr_addr;
      end
   end

   always_ff @(posedge jt_tck or posedge jt_reset) begin
      if (jt_reset)     ctrl <= CTRL_RESET;
      else if (wr_ctrl) ctrl <= dr_data;
   end

   // A dropped push in the same cycle as a clear leaves overflow set.
   always_ff @(posedge jt_tck or posedge jt_reset) begin
      if (jt_reset)       overflow <= 1'b0;
      else if (push_drop) overflow <= 1'b1;
      else if (clr_ovf)   overflow <= 1'b0;
   end

endmodule

// File: tb/tb_jtag_dr_regfile.sv
module tb_jtag_dr_regfile;

   localparam int          DATA_W  = 32;
   localparam int          ADDR_W  = 4;
   localparam int          NONCE_W = 61;
   localparam int          DEPTH   = 8;
   localparam int          DR_W    = DATA_W + ADDR_W + 2;
   localparam logic [31:0] VERSION = 32'h01000200;

   logic                jt_tck = 1'b0;
   logic                jt_reset;
   logic                nonce_push;
   logic [NONCE_W-1:0]  nonce_data;
   logic [DATA_W-1:0]   ctrl;
   logic [3:0]          fifo_count;
   logic                overflow;

   jtag_dr_regfile_if jtag ();

   jtag_dr_regfile dut (
      .jt_tck     (jt_tck),
      .jt_reset   (jt_reset),
      .jtag       (jtag),
      .nonce_push (nonce_push),
      .nonce_data (nonce_data),
      .ctrl       (ctrl),
      .fifo_count (fifo_count),
      .overflow   (overflow)
   );

   always #5 jt_tck = ~jt_tck;

   int checks   = 0;
   int failures = 0;

   // reference model: register-map level view
   logic [NONCE_W-1:0] m_q[$];
   logic               m_ovf;
   logic [31:0]        m_ctrl;
   logic [3:0]         m_addr;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NONCE_W-1:0] rand_nonce();
      logic [63:0] w;
      w = {$urandom, $urandom};
      return w[NONCE_W-1:0];
   endfunction

   function automatic logic [31:0] model_read(input logic [3:0] a);
      logic [NONCE_W-1:0] h;
      if (m_q.size() > 0) h = m_q[0];
      else h = '0;
      case (a)
         4'd0: return VERSION;
         4'd1: return (m_q.size() > 0) ? h[31:0] : 32'h0;
         4'd2: return (m_q.size() > 0) ? (32'h8000_0000 | 32'(h >> 32)) : 32'h0;
         4'd3: return {m_ovf, 31'(m_q.size())};
         4'd4: return m_ctrl;
         default: return 32'hFFFF_FFFF;
      endcase
   endfunction

   function automatic void model_push(input logic [NONCE_W-1:0] n);
      if (m_q.size() < DEPTH) m_q.push_back(n);
      else m_ovf = 1'b1;
   endfunction

   function automatic void model_reset();
      m_q.delete();
      m_ovf  = 1'b0;
      m_ctrl = 32'h0;
      m_addr = 4'hF;
   endfunction

   task automatic check_state(input string tag);
      check({tag, "_ctrl"},  64'(ctrl),       64'(m_ctrl));
      check({tag, "_count"}, 64'(fifo_count), 64'(m_q.size()));
      check({tag, "_ovf"},   64'(overflow),   64'(m_ovf));
   endtask

   task automatic push_nonce(input logic [NONCE_W-1:0] n);
      @(negedge jt_tck);
      nonce_push = 1'b1;
      nonce_data = n;
      model_push(n);
      @(posedge jt_tck);
      @(negedge jt_tck);
      nonce_push = 1'b0;
   endtask

   // One DR transaction: capture (reads reg at current pointer), shift, update.
   task automatic scan(input logic [3:0] addr, input logic wr, input logic [31:0] data,
                       input bit bad_par, input bit push_cap, input bit push_upd,
                       input string tag);
      logic [DR_W-1:0]    tx;
      logic [DR_W-1:0]    rx;
      logic [31:0]        exp;
      logic [NONCE_W-1:0] nc;
      logic [NONCE_W-1:0] nu;
      bit                 flushed;
      tx = '0;
      tx[31:0]  = data;
      tx[35:32] = addr;
      tx[36]    = wr;
      tx[37]    = ~(^tx[36:0]) ^ bad_par;
      nc = rand_nonce();
      nu = rand_nonce();

      @(negedge jt_tck);
      jtag.jt_sel = 1'b1;
      jtag.jt_capture = 1'b1;
      if (push_cap) begin
         nonce_push = 1'b1;
         nonce_data = nc;
      end
      exp = model_read(m_addr);
      if (m_addr == 4'd2 && m_q.size() > 0) void'(m_q.pop_front());
      if (push_cap) model_push(nc);
      m_addr = 4'hF;
      @(posedge jt_tck);

      for (int i = 0; i < DR_W; i++) begin
         @(negedge jt_tck);
         jtag.jt_capture = 1'b0;
         nonce_push = 1'b0;
         rx[i] = jtag.jt_tdo;
         jtag.jt_shift = 1'b1;
         jtag.jt_tdi = tx[i];
         @(posedge jt_tck);
      end

      @(negedge jt_tck);
      jtag.jt_shift = 1'b0;
      jtag.jt_update = 1'b1;
      if (push_upd) begin
         nonce_push = 1'b1;
         nonce_data = nu;
      end
      flushed = 1'b0;
      if ($countones(tx) % 2 == 1) begin
         m_addr = addr;
         if (wr && addr == 4'd4) m_ctrl = data;
         if (wr && addr == 4'd5) begin
            if (data[0]) m_ovf = 1'b0;
            if (data[1]) begin
               m_q.delete();
               flushed = 1'b1;
            end
         end
      end
      if (push_upd && !flushed) model_push(nu);
      @(posedge jt_tck);
      @(negedge jt_tck);
      jtag.jt_update = 1'b0;
      jtag.jt_sel = 1'b0;
      nonce_push = 1'b0;

      check({tag, "_rd"}, 64'(rx), 64'(exp));
      check_state(tag);
   endtask

   initial begin
      logic [3:0]  ra;
      logic [31:0] rd;
      jt_reset = 1'b1;
      jtag.jt_sel = 1'b0;
      jtag.jt_capture = 1'b0;
      jtag.jt_shift = 1'b0;
      jtag.jt_update = 1'b0;
      jtag.jt_tdi = 1'b0;
      nonce_push = 1'b0;
      nonce_data = '0;
      model_reset();
      repeat (3) @(negedge jt_tck);
      check("reset_tdo", 64'(jtag.jt_tdo), 64'd0);
      check_state("reset");
      jt_reset = 1'b0;

      // default pointer reads all-ones, then VERSION
      scan(4'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, "rd_default");
      scan(4'd4, 1'b1, 32'h0000ABCD, 1'b0, 1'b0, 1'b0, "rd_version_wr_ctrl");
      scan(4'd4, 1'b1, 32'h00001234, 1'b1, 1'b0, 1'b0, "bad_parity");
      scan(4'd4, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, "after_bad");
      scan(4'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, "rd_ctrl");

      // two nonces read lo then hi
      push_nonce(rand_nonce());
      push_nonce(rand_nonce());
      scan(4'd1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, "set_lo");
      scan(4'd2, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, "n0_lo");
      scan(4'd1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, "n0_hi");
      scan(4'd2, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, "n1_lo");
      scan(4'd2, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, "n1_hi");
      scan(4'd3, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, "empty_hi");
      scan(4'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, "status_empty");

      // overflow, clear, coincident cases
      for (int i = 0; i < 9; i++) push_nonce(rand_nonce());
      check_state("push9");
      scan(4'd5, 1'b1, 32'h1, 1'b0, 1'b0, 1'b0, "clr_ovf");
      scan(4'd2, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, "set_hi_full");
      scan(4'd3, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, "pop_push_full");
      scan(4'd5, 1'b1, 32'h1, 1'b0, 1'b0, 1'b1, "clr_with_ovf_push");
      scan(4'd5, 1'b1, 32'h2, 1'b0, 1'b0, 1'b1, "flush_with_push");
      scan(4'd5, 1'b1, 32'h1, 1'b0, 1'b0, 1'b0, "clr_again");

      // randomized traffic
      for (int i = 0; i < 40; i++) begin
         ra = 4'($urandom_range(0, 15));
         rd = $urandom;
         case ($urandom_range(0, 5))
            0: push_nonce(rand_nonce());
            1: scan(ra, 1'b0, rd, 1'b0, 1'b0, 1'b0, "rnd_read");
            2: scan(4'd4, 1'b1, rd, 1'b0, 1'b0, 1'b0, "rnd_ctrl");
            3: scan(4'd5, 1'b1, 32'($urandom_range(0, 3)), 1'b0, 1'b0, 1'($urandom_range(0, 1)), "rnd_cmd");
            4: scan(ra, 1'b1, rd, 1'b1, 1'($urandom_range(0, 1)), 1'b0, "rnd_badpar");
            default: scan(ra, 1'($urandom_range(0, 1)), rd, 1'b0, 1'b0, 1'b0, "rnd_any");
         endcase
      end

      // reset in the middle of a shift
      scan(4'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, "pre_reset");
      @(negedge jt_tck);
      jtag.jt_sel = 1'b1;
      jtag.jt_capture = 1'b1;
      @(posedge jt_tck);
      for (int i = 0; i < 10; i++) begin
         @(negedge jt_tck);
         jtag.jt_capture = 1'b0;
         jtag.jt_shift = 1'b1;
         jtag.jt_tdi = 1'b1;
         @(posedge jt_tck);
      end
      @(negedge jt_tck);
      jt_reset = 1'b1;
      jtag.jt_shift = 1'b0;
      jtag.jt_sel = 1'b0;
      model_reset();
      #1;
      check("midshift_tdo", 64'(jtag.jt_tdo), 64'd0);
      check_state("midshift_reset");
      @(negedge jt_tck);
      jt_reset = 1'b0;
      scan(4'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, "post_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
